// File: rtl/ysyx_22040228_csr_pkg.sv
// ysyx_22040228_csr_pkg
// Shared constants for the machine-mode CSR file and trap controller:
// CSR addresses, interrupt/exception codes, mstatus/mip/mie bit positions
// and the default register width.
package ysyx_22040228_csr_pkg;

    localparam int XLEN_DEFAULT = 64;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    // Interrupt / exception codes
    localparam logic [3:0] CODE_MSI     = 4'd3;
    localparam logic [3:0] CODE_MTI     = 4'd7;
    localparam logic [3:0] CODE_MEI     = 4'd11;
    localparam logic [3:0] CODE_ECALL_M = 4'd11;

    // mstatus fields
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    // mip / mie bit positions (identical layout in both registers)
    localparam int IRQ_MSI_BIT = 3;
    localparam int IRQ_MTI_BIT = 7;
    localparam int IRQ_MEI_BIT = 11;

endpackage

// File: rtl/ysyx_22040228_irq_arb.sv
// ysyx_22040228_irq_arb
// Fixed-priority interrupt selector: MEI > MSI > MTI.
// Ports:
//   en        - global enable (mstatus.MIE and PC guard already folded in)
//   msi_pend  - software interrupt pending and enabled in mie
//   mti_pend  - timer interrupt pending and enabled in mie
//   mei_pend  - external interrupt pending and enabled in mie
//   irq_take  - an interrupt should be taken
//   irq_code  - exception code of the winning interrupt
module ysyx_22040228_irq_arb
    import ysyx_22040228_csr_pkg::*;
(
    input  logic       en,
    input  logic       msi_pend,
    input  logic       mti_pend,
    input  logic       mei_pend,
    output logic       irq_take,
    output logic [3:0] irq_code
);

    always_comb begin
        irq_take = en & (msi_pend | mti_pend | mei_pend);
        // MTI is the lowest priority, so it is also the fall-through code.
        irq_code = CODE_MTI;
        if (mei_pend) begin
            irq_code = CODE_MEI;
        end else if (msi_pend) begin
            irq_code = CODE_MSI;
        end
    end

endmodule

// File: rtl/ysyx_22040228_mcsr_trap.sv
// ysyx_22040228_mcsr_trap
// Machine-mode CSR file plus trap controller, sitting beside the commit stage.
// Implements mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip,
// mcycle and minstret; takes synchronous exceptions and three level
// interrupts (software, timer, external) and supplies redirect targets.
//
// Optional feature macro: YSYX22040228_CSR_VECTOR_EN
//   defined   - mtvec.MODE writable (0/1); in mode 1 interrupts vector to
//               base + 4*code, exceptions go to base.
//   undefined - MODE reads 0; every trap goes to base.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   pc_i                  - PC of the committing instruction
//   stall_i               - freezes architectural updates (mcycle and mip excepted)
//   csr_rd_en/csr_wr_en   - CSR access strobes
//   csr_idx/csr_wdata     - CSR address and merged write data
//   csr_rdata             - combinational read data (0 when not reading)
//   instret_i             - instruction retired
//   exc_valid_i/exc_cause_i/exc_tval_i - synchronous exception at commit
//   mret_i                - mret at commit
//   irq_msip_i/irq_mtip_i/irq_meip_i   - level interrupt lines
//   trap_valid_o          - trap taken this cycle
//   trap_pc_o             - trap target
//   mret_pc_o             - mepc
module ysyx_22040228_mcsr_trap
    import ysyx_22040228_csr_pkg::*;
#(
    parameter int          XLEN         = XLEN_DEFAULT,
    parameter int unsigned RST_PC_GUARD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            csr_rd_en,
    input  logic            csr_wr_en,
    input  logic [11:0]     csr_idx,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            instret_i,
    input  logic            exc_valid_i,
    input  logic [3:0]      exc_cause_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_i,
    input  logic            irq_msip_i,
    input  logic            irq_mtip_i,
    input  logic            irq_meip_i,
    output logic            trap_valid_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic [XLEN-1:0] mret_pc_o
);

    logic            mst_mie;
    logic            mst_mpie;
    logic            mie_msie;
    logic            mie_mtie;
    logic            mie_meie;
    logic            mip_msip;
    logic            mip_mtip;
    logic            mip_meip;
    logic [XLEN-3:0] mtvec_base;
    logic            mtvec_mode;
    logic [XLEN-3:0] mepc_hi;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;

    logic            pc_ok;
    logic            irq_take;
    logic [3:0]      irq_code;
    logic [3:0]      trap_code;
    logic            csr_we;
    logic            mret_fire;
    logic [XLEN-1:0] mtvec_base_addr;

    assign pc_ok = (RST_PC_GUARD == 0) || (pc_i != '0);

    ysyx_22040228_irq_arb u_irq_arb (
        .en       (mst_mie & pc_ok),
        .msi_pend (mip_msip & mie_msie),
        .mti_pend (mip_mtip & mie_mtie),
        .mei_pend (mip_meip & mie_meie),
        .irq_take (irq_take),
        .irq_code (irq_code)
    );

    assign trap_valid_o    = ~stall_i & (exc_valid_i | irq_take);
    assign trap_code       = exc_valid_i ? exc_cause_i : irq_code;
    // A trap swallows any same-cycle CSR write and mret.
    assign csr_we          = csr_wr_en & ~stall_i & ~trap_valid_o;
    assign mret_fire       = mret_i & ~stall_i & ~trap_valid_o;
    assign mtvec_base_addr = {mtvec_base, 2'b00};
    assign mret_pc_o       = {mepc_hi, 2'b00};

    always_comb begin
        trap_pc_o = mtvec_base_addr;
`ifdef YSYX22040228_CSR_VECTOR_EN
        if (mtvec_mode && !exc_valid_i) begin
            trap_pc_o = mtvec_base_addr + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
        end
`endif
    end

    // mip follows the lines with one cycle of latency, regardless of stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mip_msip <= 1'b0;
            mip_mtip <= 1'b0;
            mip_meip <= 1'b0;
        end else begin
            mip_msip <= irq_msip_i;
            mip_mtip <= irq_mtip_i;
            mip_meip <= irq_meip_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_we && csr_idx == CSR_MCYCLE) begin
                mcycle <= csr_wdata;
            end else begin
                mcycle <= mcycle + XLEN'(1);
            end
            if (csr_we && csr_idx == CSR_MINSTRET) begin
                minstret <= csr_wdata;
            end else if (instret_i && !stall_i) begin
                minstret <= minstret + XLEN'(1);
            end
        end
    end

`ifdef YSYX22040228_CSR_VECTOR_EN
    // WARL: only modes 0 and 1 are legal; 2/3 leave the mode untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtvec_mode <= 1'b0;
        end else if (csr_we && csr_idx == CSR_MTVEC && !csr_wdata[1]) begin
            mtvec_mode <= csr_wdata[0];
        end
    end
`else
    assign mtvec_mode = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_msie   <= 1'b0;
            mie_mtie   <= 1'b0;
            mie_meie   <= 1'b0;
            mtvec_base <= '0;
            mepc_hi    <= '0;
            mscratch   <= '0;
            mcause     <= '0;
            mtval      <= '0;
        end else begin
            if (trap_valid_o) begin
                mepc_hi  <= pc_i[XLEN-1:2];
                mcause   <= {~exc_valid_i, {(XLEN-5){1'b0}}, trap_code};
                mtval    <= exc_valid_i ? exc_tval_i : '0;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret_fire) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end
            if (csr_we) begin
                case (csr_idx)
                    CSR_MSTATUS: begin
                        // mret takes precedence over a same-cycle mstatus write.
                        if (!mret_fire) begin
                            mst_mie  <= csr_wdata[MSTATUS_MIE_BIT];
                            mst_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
                        end
                    end
                    CSR_MIE: begin
                        mie_msie <= csr_wdata[IRQ_MSI_BIT];
                        mie_mtie <= csr_wdata[IRQ_MTI_BIT];
                        mie_meie <= csr_wdata[IRQ_MEI_BIT];
                    end
                    CSR_MTVEC:    mtvec_base <= csr_wdata[XLEN-1:2];
                    CSR_MSCRATCH: mscratch   <= csr_wdata;
                    CSR_MEPC:     mepc_hi    <= csr_wdata[XLEN-1:2];
                    CSR_MCAUSE:   mcause     <= csr_wdata;
                    CSR_MTVAL:    mtval      <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_rd_en) begin
            case (csr_idx)
                CSR_MSTATUS: begin
                    csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                    csr_rdata[MSTATUS_MIE_BIT]               = mst_mie;
                    csr_rdata[MSTATUS_MPIE_BIT]              = mst_mpie;
                end
                CSR_MIE: begin
                    csr_rdata[IRQ_MSI_BIT] = mie_msie;
                    csr_rdata[IRQ_MTI_BIT] = mie_mtie;
                    csr_rdata[IRQ_MEI_BIT] = mie_meie;
                end
                CSR_MTVEC:    csr_rdata = {mtvec_base, 1'b0, mtvec_mode};
                CSR_MSCRATCH: csr_rdata = mscratch;
                CSR_MEPC:     csr_rdata = mret_pc_o;
                CSR_MCAUSE:   csr_rdata = mcause;
                CSR_MTVAL:    csr_rdata = mtval;
                CSR_MIP: begin
                    csr_rdata[IRQ_MSI_BIT] = mip_msip;
                    csr_rdata[IRQ_MTI_BIT] = mip_mtip;
                    csr_rdata[IRQ_MEI_BIT] = mip_meip;
                end
                CSR_MCYCLE:   csr_rdata = mcycle;
                CSR_MINSTRET: csr_rdata = minstret;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040228_mcsr_trap.sv
// Testbench for ysyx_22040228_mcsr_trap (XLEN=64, RST_PC_GUARD=1).
module tb_ysyx_22040228_mcsr_trap;

`ifdef YSYX22040228_CSR_VECTOR_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc_i = '0;
    logic        stall_i = 1'b0;
    logic        csr_rd_en = 1'b0;
    logic        csr_wr_en = 1'b0;
    logic [11:0] csr_idx = '0;
    logic [63:0] csr_wdata = '0;
    logic [63:0] csr_rdata;
    logic        instret_i = 1'b0;
    logic        exc_valid_i = 1'b0;
    logic [3:0]  exc_cause_i = '0;
    logic [63:0] exc_tval_i = '0;
    logic        mret_i = 1'b0;
    logic        irq_msip_i = 1'b0;
    logic        irq_mtip_i = 1'b0;
    logic        irq_meip_i = 1'b0;
    logic        trap_valid_o;
    logic [63:0] trap_pc_o;
    logic [63:0] mret_pc_o;

    always #5 clk = ~clk;

    ysyx_22040228_mcsr_trap #(.XLEN(64), .RST_PC_GUARD(1)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .stall_i(stall_i),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .instret_i(instret_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .irq_msip_i(irq_msip_i), .irq_mtip_i(irq_mtip_i),
        .irq_meip_i(irq_meip_i), .trap_valid_o(trap_valid_o), .trap_pc_o(trap_pc_o),
        .mret_pc_o(mret_pc_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // CSRs held as whole architectural words; mstatus as its two live bits.
    logic        m_ie, m_pie;
    logic [63:0] m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_mcycle, m_minstret;

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 64'h1800 | (64'(m_ie) << 3) | (64'(m_pie) << 7);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hB00: return m_mcycle;
            12'hB02: return m_minstret;
            default: return 64'd0;
        endcase
    endfunction

    // Highest-priority enabled pending interrupt, or -1.
    function automatic int m_code();
        int prio [3] = '{11, 3, 7};
        logic [63:0] act;
        act = m_mip & m_mie;
        foreach (prio[i]) if (act[prio[i]]) return prio[i];
        return -1;
    endfunction

    function automatic logic [63:0] m_trap_pc();
        logic [63:0] base;
        base = m_mtvec & ~64'h3;
        if (VEC && m_mtvec[0] && !exc_valid_i) return base + 64'(4 * m_code());
        return base;
    endfunction

    logic m_pend, m_take, m_wr, m_mret;
    assign m_pend = m_ie && (m_code() >= 0) && (pc_i != 64'd0);
    assign m_take = !stall_i && (exc_valid_i || m_pend);
    assign m_wr   = csr_wr_en && !stall_i && !m_take;
    assign m_mret = mret_i && !stall_i && !m_take;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ie <= 0; m_pie <= 0; m_mie <= 0; m_mip <= 0; m_mtvec <= 0;
            m_mscratch <= 0; m_mepc <= 0; m_mcause <= 0; m_mtval <= 0;
            m_mcycle <= 0; m_minstret <= 0;
        end else begin
            m_mip <= (64'(irq_meip_i) << 11) | (64'(irq_mtip_i) << 7) | (64'(irq_msip_i) << 3);
            m_mcycle <= (m_wr && csr_idx == 12'hB00) ? csr_wdata : m_mcycle + 64'd1;
            if (m_wr && csr_idx == 12'hB02) m_minstret <= csr_wdata;
            else if (instret_i && !stall_i) m_minstret <= m_minstret + 64'd1;
            if (m_take) begin
                m_mepc   <= pc_i & ~64'h3;
                m_mcause <= exc_valid_i ? 64'(exc_cause_i) : ((64'd1 << 63) | 64'(m_code()));
                m_mtval  <= exc_valid_i ? exc_tval_i : 64'd0;
                m_pie    <= m_ie;
                m_ie     <= 0;
            end else if (m_mret) begin
                m_ie  <= m_pie;
                m_pie <= 1;
            end
            if (m_wr) begin
                case (csr_idx)
                    12'h300: if (!m_mret) begin m_ie <= csr_wdata[3]; m_pie <= csr_wdata[7]; end
                    12'h304: m_mie <= csr_wdata & 64'h888;
                    12'h305: begin
                        if (VEC) m_mtvec <= (csr_wdata & ~64'h3) |
                                            (csr_wdata[1] ? (m_mtvec & 64'h3) : (csr_wdata & 64'h1));
                        else     m_mtvec <= csr_wdata & ~64'h3;
                    end
                    12'h340: m_mscratch <= csr_wdata;
                    12'h341: m_mepc <= csr_wdata & ~64'h3;
                    12'h342: m_mcause <= csr_wdata;
                    12'h343: m_mtval <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rdata", csr_rdata, csr_rd_en ? m_read(csr_idx) : 64'd0);
            chk("trap_valid", 64'(trap_valid_o), 64'(m_take));
            chk("mret_pc", mret_pc_o, m_mepc);
            if (m_take) chk("trap_pc", trap_pc_o, m_trap_pc());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        csr_wr_en = 1; csr_idx = a; csr_wdata = d;
        cyc();
        csr_wr_en = 0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [63:0] exp);
        csr_rd_en = 1; csr_idx = a;
        @(negedge clk);
        chk(name, csr_rdata, exp);
        cyc();
        csr_rd_en = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_rdata", csr_rdata, 0);
        chk("rst_trap_valid", 64'(trap_valid_o), 0);
        chk("rst_mret_pc", mret_pc_o, 0);
        cyc(); cyc();
        rst = 0;
        rd("mcycle_at_release", 12'hB00, 0);
        rd("mstatus_reset", 12'h300, 64'h1800);
        rd("mtvec_reset", 12'h305, 0);
        rd("minstret_reset", 12'hB02, 0);
        rd("mcycle_count", 12'hB00, 4);
        rd("unimpl_read", 12'h7C0, 0);

        // timer interrupt
        wr(12'h305, 64'h8000_0100);
        wr(12'h304, 64'h80);
        wr(12'h300, 64'h8);
        pc_i = 64'h8000_0040; irq_mtip_i = 1;
        cyc();
        @(negedge clk);
        chk("mti_trap_valid", 64'(trap_valid_o), 1);
        chk("mti_trap_pc", trap_pc_o, 64'h8000_0100);
        cyc();
        irq_mtip_i = 0;
        rd("mti_mepc", 12'h341, 64'h8000_0040);
        rd("mti_mcause", 12'h342, 64'h8000_0000_0000_0007);
        rd("mti_mstatus", 12'h300, 64'h1880);
        rd("mti_mtval", 12'h343, 0);

        // mret
        mret_i = 1;
        @(negedge clk);
        chk("mret_pc", mret_pc_o, 64'h8000_0040);
        cyc();
        mret_i = 0;
        rd("mret_mstatus", 12'h300, 64'h1888);

        // stalled mret with pending interrupt
        wr(12'h300, 64'h8);
        irq_mtip_i = 1; stall_i = 1; mret_i = 1;
        cyc();
        @(negedge clk);
        chk("stall_trap_valid", 64'(trap_valid_o), 0);
        cyc();
        mret_i = 0; irq_mtip_i = 0;
        cyc(); cyc();
        stall_i = 0;
        rd("stall_mstatus", 12'h300, 64'h1808);

        // all three interrupts, priority, mtvec WARL
        wr(12'h304, 64'h888);
        wr(12'h305, 64'h8000_0101);
        rd("mtvec_mode1", 12'h305, VEC ? 64'h8000_0101 : 64'h8000_0100);
        wr(12'h305, 64'h8000_0102);
        rd("mtvec_mode2_keep", 12'h305, VEC ? 64'h8000_0101 : 64'h8000_0100);
        irq_msip_i = 1; irq_mtip_i = 1; irq_meip_i = 1;
        cyc();
        @(negedge clk);
        chk("all_trap_valid", 64'(trap_valid_o), 1);
        chk("all_trap_pc", trap_pc_o, VEC ? 64'h8000_012C : 64'h8000_0100);
        cyc();
        irq_msip_i = 0; irq_mtip_i = 0; irq_meip_i = 0;
        rd("all_mcause", 12'h342, 64'h8000_0000_0000_000B);
        rd("all_mstatus", 12'h300, 64'h1880);

        // exception beats pending interrupt and same-cycle CSR write
        irq_mtip_i = 1;
        wr(12'h300, 64'h8);
        exc_valid_i = 1; exc_cause_i = 4'd2; exc_tval_i = 64'hDEAD;
        csr_wr_en = 1; csr_idx = 12'h340; csr_wdata = 64'h1234;
        @(negedge clk);
        chk("exc_trap_valid", 64'(trap_valid_o), 1);
        chk("exc_trap_pc", trap_pc_o, 64'h8000_0100);
        cyc();
        exc_valid_i = 0; csr_wr_en = 0; irq_mtip_i = 0;
        rd("exc_mcause", 12'h342, 64'd2);
        rd("exc_mtval", 12'h343, 64'hDEAD);
        rd("exc_mscratch", 12'h340, 0);

        // PC guard and mepc alignment
        pc_i = 0; irq_mtip_i = 1;
        wr(12'h300, 64'h8);
        @(negedge clk);
        chk("guard_trap_valid", 64'(trap_valid_o), 0);
        cyc();
        pc_i = 64'h47;
        @(negedge clk);
        chk("unguard_trap_valid", 64'(trap_valid_o), 1);
        cyc();
        irq_mtip_i = 0;
        rd("guard_mepc", 12'h341, 64'h44);

        // counters
        wr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        instret_i = 1;
        cyc();
        instret_i = 0;
        rd("minstret_wrap", 12'hB02, 0);
        instret_i = 1;
        wr(12'hB02, 64'h10);
        instret_i = 0;
        rd("minstret_wr_wins", 12'hB02, 64'h10);
        wr(12'hB00, 64'd5);
        rd("mcycle_wr", 12'hB00, 64'd5);
        rd("mcycle_next", 12'hB00, 64'd6);

        // misc CSRs
        wr(12'h341, 64'h1003);
        rd("mepc_wr", 12'h341, 64'h1000);
        irq_meip_i = 1;
        cyc();
        rd("mip_meip", 12'h344, 64'h800);
        irq_meip_i = 0;

        // asynchronous reset mid-operation
        rst = 1;
        #1;
        chk("arst_rdata", csr_rdata, 0);
        chk("arst_mret_pc", mret_pc_o, 0);
        chk("arst_trap_valid", 64'(trap_valid_o), 0);
        cyc();
        rst = 0;
        rd("arst_mepc", 12'h341, 0);
        rd("arst_mstatus", 12'h300, 64'h1800);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
